// File: rtl/cache_control_sa.sv
// cache_control_sa: 2-way set-associative, write-back, write-allocate word cache.
// It sits between a CPU valid/ready load/store port and a memory bus that
// completes each request with an ack. Replacement uses one pseudo-LRU bit per
// set. A dirty victim is written back before the line is refilled.
// Optional feature macro: CACHE_STATS_EN adds the stat_hits/stat_misses counters.
module cache_control_sa #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_RESP} state_t;

  state_t r_state, w_next;

  // Line storage: tag/data are not reset, valid/dirty/LRU are.
  logic [TAG_W-1:0]  r_tag   [2][SETS];
  logic [DATA_W-1:0] r_data  [2][SETS];
  logic [SETS-1:0]   r_val   [2];
  logic [SETS-1:0]   r_dirty [2];
  logic [SETS-1:0]   r_lru;

  // Request captured on accept; r_way is the hit way or the chosen victim.
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_way;
  logic [DATA_W-1:0] r_rdata;
  logic              r_hit;

  logic [INDEX_W-1:0] w_idx, w_ridx;
  logic [TAG_W-1:0]   w_tag, w_rtag;
  logic               w_hit0, w_hit1, w_hit, w_hway;
  logic               w_vict, w_vdirty;
  logic               w_acc, w_fill_done;
  logic [DATA_W-1:0]  w_hdata;
  logic               w_we, w_we_way;
  logic [INDEX_W-1:0] w_we_idx;
  logic [TAG_W-1:0]   w_we_tag;
  logic [DATA_W-1:0]  w_we_data;

  assign w_idx  = req_addr[INDEX_W-1:0];
  assign w_tag  = req_addr[ADDR_W-1:INDEX_W];
  assign w_ridx = r_addr[INDEX_W-1:0];
  assign w_rtag = r_addr[ADDR_W-1:INDEX_W];

  // Lookup happens straight off the request lines in the accept cycle.
  assign w_hit0   = r_val[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1   = r_val[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit    = w_hit0 || w_hit1;
  assign w_hway   = w_hit1;
  assign w_hdata  = r_data[w_hway][w_idx];
  // Fill empty ways in order before evicting the LRU way.
  assign w_vict   = !r_val[0][w_idx] ? 1'b0 : (!r_val[1][w_idx] ? 1'b1 : r_lru[w_idx]);
  assign w_vdirty = r_val[w_vict][w_idx] && r_dirty[w_vict][w_idx];

  assign w_acc       = req_valid && (r_state == S_IDLE);
  assign w_fill_done = (r_state == S_FILL) && mem_ack;

  // A single write port into tag/data serves both write hits and refills.
  assign w_we      = (w_acc && w_hit && req_wr) || w_fill_done;
  assign w_we_way  = w_fill_done ? r_way  : w_hway;
  assign w_we_idx  = w_fill_done ? w_ridx : w_idx;
  assign w_we_tag  = w_fill_done ? w_rtag : w_tag;
  assign w_we_data = w_fill_done ? (r_wr ? r_wdata : mem_rdata) : req_wdata;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state. Bus outputs decode from state alone, so reset drops them at once.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_hit)         w_next = S_RESP;
          else if (w_vdirty) w_next = S_WB;
          else               w_next = S_FILL;
        end
      end
      S_WB: begin
        mem_wr    = 1'b1;
        mem_addr  = {r_tag[r_way][w_ridx], w_ridx};
        mem_wdata = r_data[r_way][w_ridx];
        if (mem_ack) w_next = S_FILL;
      end
      S_FILL: begin
        mem_rd   = 1'b1;
        mem_addr = r_addr;
        if (mem_ack) w_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, line state bits, LRU update and the response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val[0]   <= '0;
      r_val[1]   <= '0;
      r_dirty[0] <= '0;
      r_dirty[1] <= '0;
      r_lru      <= '0;
      r_addr     <= '0;
      r_wr       <= 1'b0;
      r_wdata    <= '0;
      r_way      <= 1'b0;
      r_rdata    <= '0;
      r_hit      <= 1'b0;
    end else begin
      if (w_acc) begin
        r_addr  <= req_addr;
        r_wr    <= req_wr;
        r_wdata <= req_wdata;
        r_way   <= w_hit ? w_hway : w_vict;
        if (w_hit) begin
          r_lru[w_idx] <= ~w_hway;
          r_hit        <= 1'b1;
          r_rdata      <= req_wr ? req_wdata : w_hdata;
          if (req_wr) r_dirty[w_hway][w_idx] <= 1'b1;
        end
      end
      if (w_fill_done) begin
        r_val[r_way][w_ridx]   <= 1'b1;
        r_dirty[r_way][w_ridx] <= r_wr;
        r_lru[w_ridx]          <= ~r_way;
        r_hit                  <= 1'b0;
        r_rdata                <= w_we_data;
      end
    end
  end

  // Tag/data arrays: plain write port, no reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_tag[w_we_way][w_we_idx]  <= w_we_tag;
      r_data[w_we_way][w_we_idx] <= w_we_data;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_hit   = r_hit;

`ifdef CACHE_STATS_EN
  // Count hits and misses as their responses go out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (r_state == S_RESP) begin
      if (r_hit) stat_hits   <= stat_hits + 32'd1;
      else       stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_control_sa.sv
// Directed bench for cache_control_sa with a small memory responder in the request task.
module tb_cache_control_sa;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [29:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_rdata;
  logic        mem_rd, mem_wr, mem_ack;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  cache_control_sa dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one request, answer bus requests after dly wait cycles, check the response.
  task automatic do_req(input string tag, input logic wr, input logic [29:0] addr,
                        input logic [31:0] wdata, input int dly, input logic [31:0] fdata,
                        input logic exp_hit, input logic [31:0] exp_rdata,
                        input logic exp_wb, input logic [29:0] wb_addr, input logic [31:0] wb_data);
    bit          done = 0, saw_wr = 0, saw_rd = 0, both = 0, unstable = 0;
    logic [29:0] wa = '0, ra = '0;
    logic [31:0] wd = '0;
    int          cnt = 0, lat = 0;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_idle_resp"}, {31'd0, resp_valid}, 32'd0);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      // Scramble request lines: they must have been latched on accept.
      req_valid = 1'b0; req_addr = '1; req_wdata = 32'hDEADBEEF; req_wr = ~wr;
      mem_ack = 1'b0;
      if (mem_rd && mem_wr) both = 1;
      if (resp_valid) begin
        done = 1;
        lat  = c;
      end else if (mem_wr || mem_rd) begin
        if (mem_wr) begin
          if (saw_wr && (mem_addr != wa || mem_wdata != wd)) unstable = 1;
          saw_wr = 1; wa = mem_addr; wd = mem_wdata;
        end
        if (mem_rd) begin
          if (saw_rd && mem_addr != ra) unstable = 1;
          saw_rd = 1; ra = mem_addr;
        end
        if (cnt == dly) begin
          mem_ack = 1'b1; mem_rdata = fdata; cnt = 0;
        end else cnt++;
      end
    end
    chk({tag, "_timeout"}, {31'd0, done}, 32'd1);
    chk({tag, "_hit"}, {31'd0, resp_hit}, {31'd0, exp_hit});
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_wb"}, {31'd0, saw_wr}, {31'd0, exp_wb});
    chk({tag, "_rd"}, {31'd0, saw_rd}, {31'd0, ~exp_hit});
    chk({tag, "_both"}, {31'd0, both}, 32'd0);
    chk({tag, "_stable"}, {31'd0, unstable}, 32'd0);
    if (exp_wb) begin
      chk({tag, "_wb_addr"}, {2'b0, wa}, {2'b0, wb_addr});
      chk({tag, "_wb_data"}, wd, wb_data);
    end
    if (!exp_hit) chk({tag, "_rd_addr"}, {2'b0, ra}, {2'b0, addr});
    else          chk({tag, "_lat"}, lat, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rvalid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_rhit"}, {31'd0, resp_hit}, 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_mrd"}, {31'd0, mem_rd}, 32'd0);
    chk({tag, "_mwr"}, {31'd0, mem_wr}, 32'd0);
    chk({tag, "_maddr"}, {2'b0, mem_addr}, 32'd0);
    chk({tag, "_mwdata"}, mem_wdata, 32'd0);
`ifdef CACHE_STATS_EN
    chk({tag, "_shits"}, stat_hits, 32'd0);
    chk({tag, "_smiss"}, stat_misses, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #1 chk_reset_outs("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 1: cold write miss, write-allocate keeps the CPU data, not the fill data.
    do_req("s1_wr0", 1'b1, 30'd0, 32'h87654321, 3, 32'h12345678, 1'b0, 32'h87654321, 1'b0, '0, '0);
    // 2: read hit on the dirty line.
    do_req("s2_rd0", 1'b0, 30'd0, 32'h0, 0, 32'h0, 1'b1, 32'h87654321, 1'b0, '0, '0);
    // 3: read miss then hit on another set.
    do_req("s3_rd1", 1'b0, 30'd1, 32'h0, 1, 32'h12345678, 1'b0, 32'h12345678, 1'b0, '0, '0);
    do_req("s3_rd1h", 1'b0, 30'd1, 32'h0, 0, 32'h0, 1'b1, 32'h12345678, 1'b0, '0, '0);
    // 4: 256 takes the empty way; 512 evicts dirty addr 0 via writeback.
    do_req("s4_rd256", 1'b0, 30'd256, 32'h0, 2, 32'h00000256, 1'b0, 32'h00000256, 1'b0, '0, '0);
    do_req("s4_rd512", 1'b0, 30'd512, 32'h0, 2, 32'h00000512, 1'b0, 32'h00000512, 1'b1, 30'd0, 32'h87654321);
`ifdef CACHE_STATS_EN
    @(negedge clk);
    chk("stat_hits", stat_hits, 32'd2);
    chk("stat_misses", stat_misses, 32'd4);
`endif
    // 256 must have survived the eviction of addr 0.
    do_req("s4_rd256h", 1'b0, 30'd256, 32'h0, 0, 32'h0, 1'b1, 32'h00000256, 1'b0, '0, '0);

    // 5: reset in the middle of a FILL.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 30'd1024;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("s5_pre_mrd", {31'd0, mem_rd}, 32'd1);
    chk("s5_pre_maddr", {2'b0, mem_addr}, 32'd1024);
    #2 rst = 1'b0;
    #1 chk_reset_outs("s5_rst");
    @(negedge clk);
    req_valid = 1'b1; req_addr = 30'd256;
    @(posedge clk);
    #1 chk_reset_outs("s5_ign");
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    do_req("s5_rd256", 1'b0, 30'd256, 32'h0, 0, 32'h00000256, 1'b0, 32'h00000256, 1'b0, '0, '0);

    // Write hit returns the written word; dirty line later written back with zero-wait acks.
    do_req("s6_wr256", 1'b1, 30'd256, 32'hCAFEF00D, 0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, '0, '0);
    do_req("s6_rd256", 1'b0, 30'd256, 32'h0, 0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, '0, '0);
    do_req("s6_rd512", 1'b0, 30'd512, 32'h0, 0, 32'h55AA0512, 1'b0, 32'h55AA0512, 1'b0, '0, '0);
    do_req("s6_rd768", 1'b0, 30'd768, 32'h0, 0, 32'h00000768, 1'b0, 32'h00000768, 1'b1, 30'd256, 32'hCAFEF00D);
    do_req("s6_rd512h", 1'b0, 30'd512, 32'h0, 0, 32'h0, 1'b1, 32'h55AA0512, 1'b0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_control_sa.md
Name: cache_control_sa

Overview:
- Parametrised successor of the direct-mapped cache controller: 2-way set-associative, write-back, write-allocate word cache.
- Sits between a CPU load/store port and the memory bus.
- Adds a valid/ready request handshake, a memory handshake with ack, pseudo-LRU replacement and dirty-victim writeback.
- One-word lines; addresses are word addresses.

Parameters:
ADDR_W, 30, word-address width
DATA_W, 32, data word width
INDEX_W, 8, set index width; 2**INDEX_W sets, tag width = ADDR_W-INDEX_W

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  controller can accept a request
req_wr  in  1  1=write, 0=read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  DATA_W  read data (write: the written word)
resp_hit  out  1  qualifies resp_valid: 1=hit, 0=miss serviced
mem_rd  out  1  memory read request, held until mem_ack
mem_wr  out  1  memory write request, held until mem_ack
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  writeback data
mem_rdata  in  DATA_W  fill data, valid with mem_ack during read
mem_ack  in  1  one-cycle completion of mem_rd or mem_wr

Behaviour:
- Storage per set: 2 ways of {valid, dirty, tag, data}, plus one LRU bit per set (points at the way to evict next).
- Address split: index = req_addr[INDEX_W-1:0], tag = req_addr[ADDR_W-1:INDEX_W].
- States: IDLE, WB, FILL, RESP.
- req_ready = (state==IDLE). Accept = req_valid && req_ready. The request is latched on accept.
- Lookup occurs combinationally in the accept cycle.
- Hit, read: latch data and go to RESP.
- Hit, write: write data, set dirty, go to RESP.
- On any hit, LRU bit := other way.
- Hit latency: resp_valid high exactly 1 cycle after the accept edge, resp_hit=1. RESP->IDLE unconditionally, so peak throughput is 1 request per 2 cycles.
- Miss, victim selection: invalid way0 first, then invalid way1, otherwise the LRU way.
- Miss, dirty valid victim -> WB. Otherwise -> FILL.
- WB: mem_wr=1, mem_addr={victim tag,index}, mem_wdata=victim data, held stable until mem_ack; then -> FILL.
- FILL: mem_rd=1, mem_addr=latched addr, held until mem_ack.
- On FILL mem_ack:
  - Read: line := mem_rdata, dirty=0.
  - Write: line := req_wdata, dirty=1 (mem_rdata discarded).
  - In both cases valid=1, LRU := other way, then -> RESP with resp_hit=0.
- mem_rd and mem_wr are never both high. mem_ack outside WB/FILL is ignored.
- mem_ack may arrive in the first cycle of WB/FILL (zero-wait memory). Wait states are unbounded.
- req_* inputs are sampled only on accept; later changes have no effect.
- Reset (rst low, asynchronous):
  - state=IDLE; all valid, dirty and LRU bits cleared.
  - resp_valid=0, resp_hit=0, resp_rdata=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0; req_ready=1.
  - Requests are ignored while rst is low.
  - Reset mid-WB/FILL abandons the bus transaction immediately and loses dirty data.
- Data arrays need not be reset.

Optional Feature:
CACHE_STATS_EN
- Defined: adds outputs stat_hits[31:0] and stat_misses[31:0], both 0 on reset.
  - stat_hits increments on every resp_valid with resp_hit=1.
  - stat_misses increments on every resp_valid with resp_hit=0.
  - Both wrap at 2**32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Cold cache, write addr 0 data 0x87654321; ack FILL after 3 cycles with mem_rdata 0x12345678 -> no mem_wr; mem_rd with mem_addr 0; resp_valid, resp_hit=0, resp_rdata 0x87654321.
2. Read addr 0 -> resp_valid 1 cycle after accept, resp_hit=1, resp_rdata 0x87654321, no mem_rd/mem_wr.
3. Read addr 1 with mem_rdata 0x12345678 -> miss, rdata 0x12345678. Re-read addr 1 -> hit, same data.
4. Read addr 256 then addr 512 (index 0 after scenarios 1-2):
   - 256 fills the way not holding addr 0, no writeback.
   - 512 evicts dirty addr 0: mem_wr with mem_addr 0 and mem_wdata 0x87654321, then mem_rd with mem_addr 512.
5. Assert rst during FILL of addr 1024 -> mem_rd drops asynchronously, outputs reach reset values. Afterwards read addr 256 -> miss.
6. CACHE_STATS_EN defined, run scenarios 1-4 -> stat_hits=2, stat_misses=4. Build without the macro compiles with no stat_* ports.
